neuron_bus_driver: RTL

//  Host-side encoder for the 32-bit neuron shared bus; the transmit end of the neuron bus decode.

---
 rtl/neuron_bus_pkg.sv | 36 +++
 rtl/neuron_bus_driver_if.sv | 25 ++
 rtl/neuron_cmd_fifo.sv | 41 ++++
 rtl/neuron_bus_driver.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/neuron_bus_pkg.sv
// Shared types and bus bit positions for the neuron shared-bus driver.
package neuron_bus_pkg;

   localparam int unsigned BUS_W      = 32;
   localparam int unsigned CMD_DATA_W = 22;
   localparam int unsigned DATA_W     = 16;

   localparam int unsigned DATA_LSB = 0;
   localparam int unsigned RD_BIT   = 16;
   localparam int unsigned WR_BIT   = 17;
   localparam int unsigned CS_BIT   = 18;
   localparam int unsigned THR_BIT  = 20;
   localparam int unsigned SPK_BIT  = 21;

   typedef enum logic [1:0] {
      OP_WRITE  = 2'b00,
      OP_READ   = 2'b01,
      OP_THRESH = 2'b10,
      OP_RSVD   = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      THR
   } state_e;

   typedef struct packed {
      op_e                   op;
      logic [CMD_DATA_W-1:0] data;
      logic                  spike;
   } cmd_t;

endpackage

// File: rtl/neuron_bus_driver_if.sv
// Command handshake and bus-side signals of the neuron bus driver.
interface neuron_bus_driver_if;
   import neuron_bus_pkg::*;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [1:0]            cmd_op;
   logic [CMD_DATA_W-1:0] cmd_data;
   logic                  cmd_spike;
   logic [BUS_W-1:0]      bus;
   logic                  busy;
   logic                  done;
   logic                  err;

   modport master (
      output cmd_valid, cmd_op, cmd_data, cmd_spike,
      input  cmd_ready, bus, busy, done, err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, cmd_spike,
      output cmd_ready, bus, busy, done, err
   );

endinterface

// File: rtl/neuron_cmd_fifo.sv
// Synchronous command FIFO (power-of-2 depth >= 2) with full/empty flags.
module neuron_cmd_fifo
   import neuron_bus_pkg::*;
#(
   parameter int unsigned Depth = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  cmd_t wdata,
   input  logic pop,
   output cmd_t rdata,
   output logic full,
   output logic empty
);

   localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;

   cmd_t        mem_q [Depth];
   logic [AW:0] wptr_q, rptr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push && !full) wptr_q <= wptr_q + 1'b1;
         if (pop && !empty) rptr_q <= rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) mem_q[wptr_q[AW-1:0]] <= wdata;
   end

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign rdata = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/neuron_bus_driver.sv
// Host-side encoder sequencing commands into registered neuron bus words.
// Optional command buffering is enabled with NEURON_BUS_FIFO_EN.
module neuron_bus_driver
   import neuron_bus_pkg::*;
#(
   parameter int unsigned STROBE_CYCLES = 1,
   parameter int unsigned HOLD_CYCLES   = 1,
   parameter int unsigned FIFO_DEPTH    = 4
) (
   input logic                clk,
   input logic                rst,
   neuron_bus_driver_if.slave nb
);

   localparam int unsigned CntMax = ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES
                                                                   : HOLD_CYCLES) - 1;
   localparam int unsigned CntW   = (CntMax > 0) ? $clog2(CntMax + 1) : 1;

   if (STROBE_CYCLES < 1 || HOLD_CYCLES < 1 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
      $error("neuron_bus_driver: invalid parameter value");
   end

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   cmd_t             cmd_q, cmd_d;
   logic [BUS_W-1:0] bus_q, bus_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   cmd_t             in_cmd;
   cmd_t             src_cmd;
   logic             src_valid;

   assign in_cmd.op    = op_e'(nb.cmd_op);
   assign in_cmd.data  = nb.cmd_data;
   assign in_cmd.spike = nb.cmd_spike;

`ifdef NEURON_BUS_FIFO_EN
   logic fifo_full, fifo_empty;

   neuron_cmd_fifo #(
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (nb.cmd_valid && nb.cmd_ready),
      .wdata (in_cmd),
      .pop   ((state_q == IDLE) && !fifo_empty),
      .rdata (src_cmd),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign nb.cmd_ready = !fifo_full && !rst;
   assign src_valid    = !fifo_empty;
   assign nb.busy      = (state_q != IDLE) || !fifo_empty;
`else
   assign nb.cmd_ready = (state_q == IDLE) && !rst;
   assign src_valid    = nb.cmd_valid && !rst;
   assign src_cmd      = in_cmd;
   assign nb.busy      = (state_q != IDLE);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cmd_q   <= '0;
         bus_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cmd_q   <= cmd_d;
         bus_q   <= bus_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cmd_d   = cmd_q;
      err_d   = 1'b0;
      bus_d   = '0;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (src_valid) begin
               unique case (src_cmd.op)
                  OP_WRITE, OP_READ: begin
                     state_d = SETUP;
                     cmd_d   = src_cmd;
                  end
                  // A threshold word without bit 20 set cannot be expressed on the bus.
                  OP_THRESH: begin
                     if (src_cmd.data[THR_BIT]) begin
                        state_d = THR;
                        cmd_d   = src_cmd;
                     end else begin
                        err_d = 1'b1;
                     end
                  end
                  default: err_d = 1'b1;
               endcase
            end
         end
         SETUP: begin
            state_d = STROBE;
            cnt_d   = CntW'(STROBE_CYCLES - 1);
         end
         STROBE: begin
            if (cnt_q == '0) begin
               state_d = HOLD;
               cnt_d   = CntW'(HOLD_CYCLES - 1);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         HOLD: begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d = cnt_q - 1'b1;
         end
         THR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Bus word is a function of the state being entered, so the output is registered.
      case (state_d)
         SETUP, STROBE, HOLD: begin
            bus_d[DATA_LSB +: DATA_W] = cmd_d.data[DATA_W-1:0];
            bus_d[CS_BIT]             = 1'b1;
            bus_d[SPK_BIT]            = cmd_d.spike;
            if (state_d == STROBE) begin
               if (cmd_d.op == OP_READ) bus_d[RD_BIT] = 1'b1;
               else                     bus_d[WR_BIT] = 1'b1;
            end
            done_d = (state_d == HOLD) && (cnt_d == '0);
         end
         THR: begin
            bus_d[CMD_DATA_W-1:0] = cmd_d.data;
            done_d                = 1'b1;
         end
         default: ;
      endcase
   end

   assign nb.bus  = bus_q;
   assign nb.done = done_q;
   assign nb.err  = err_q;

endmodule
